// File: rtl/wildneq_arb_if.sv
// ---------------------------------------------------------------------------
// wildneq_arb_if
//   Bundles the request and response handshakes of the shared wildcard
//   inequality compare unit.
//
//   Request side (one lane per requester, lane i at [i*W +: W]):
//     req_valid[NREQ]       requester has a compare pending
//     req_ready[NREQ]       grant; transfer when valid & ready
//     req_a[NREQ*A_W]       operand A
//     req_b[NREQ*B_W]       operand B
//     req_mask[NREQ*B_W]    don't-care bits of B (1 = ignore)
//   Response side:
//     resp_valid / resp_ready   response handshake
//     resp_id[ID_W]             originating requester
//     resp_neq[RES_W]           compare result, bit 0 significant
//
//   Modports: slave = compare unit, master = clients/consumer.
// ---------------------------------------------------------------------------
interface wildneq_arb_if #(
   parameter int NREQ  = 4,
   parameter int A_W   = 9,
   parameter int B_W   = 6,
   parameter int RES_W = 1,
   parameter int ID_W  = 2
);
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*A_W-1:0] req_a;
   logic [NREQ*B_W-1:0] req_b;
   logic [NREQ*B_W-1:0] req_mask;
   logic                resp_valid;
   logic                resp_ready;
   logic [ID_W-1:0]     resp_id;
   logic [RES_W-1:0]    resp_neq;

   modport slave (
      input  req_valid, req_a, req_b, req_mask, resp_ready,
      output req_ready, resp_valid, resp_id, resp_neq
   );

   modport master (
      output req_valid, req_a, req_b, req_mask, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_neq
   );
endinterface

// File: rtl/wildneq_arb.sv
// ---------------------------------------------------------------------------
// wildneq_arb
//   One pipelined wildcard-inequality (A !=? B) comparator shared by NREQ
//   requesters through a round-robin arbiter. B's don't-care bits are
//   carried by a 2-state mask instead of X/Z.
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset, synchronous release
//     bus        wildneq_arb_if.slave (request lanes + response port)
//     stat_cmp   [15:0] saturating count of response handshakes   (macro)
//     stat_neq   [15:0] saturating count of handshakes with neq=1 (macro)
//
//   Optional feature: define WILDNEQ_ARB_STATS_EN to add stat_cmp/stat_neq.
//   Without it the counters and ports do not exist.
//
//   Pipeline: arbitration (combinational) -> S1 issue register -> compare
//   -> S2 response register. One response per cycle, two-cycle latency.
// ---------------------------------------------------------------------------
module wildneq_arb #(
   parameter int NREQ   = 4,
   parameter int A_W    = 9,
   parameter int B_W    = 6,
   parameter int SIGNED = 0,
   parameter int RES_W  = 1,
   parameter int ID_W   = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   wildneq_arb_if.slave bus
`ifdef WILDNEQ_ARB_STATS_EN
   ,
   output logic [15:0]  stat_cmp,
   output logic [15:0]  stat_neq
`endif
);

   localparam int CW    = (A_W > B_W) ? A_W : B_W;
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0]  GRANT_LSB = NREQ'(1);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NREQ - 1);

   // Operand extension to the compare width. Sign extension of the mask
   // replicates its MSB, so a wildcarded sign bit keeps the extension
   // bits wildcarded as well.
   function automatic logic [CW-1:0] ext_a(input logic [A_W-1:0] v);
      if (SIGNED != 0) return CW'($signed(v));
      else             return CW'(v);
   endfunction

   function automatic logic [CW-1:0] ext_b(input logic [B_W-1:0] v);
      if (SIGNED != 0) return CW'($signed(v));
      else             return CW'(v);
   endfunction

   function automatic logic wild_neq(input logic [CW-1:0] a,
                                     input logic [CW-1:0] b,
                                     input logic [CW-1:0] m);
      return |((a ^ b) & ~m);
   endfunction

   // Control state
   logic [PTR_W-1:0] rr_ptr_q,     rr_ptr_d;
   logic             s1_valid_q,   s1_valid_d;
   logic             resp_valid_q, resp_valid_d;
   logic [ID_W-1:0]  resp_id_q,    resp_id_d;
   logic [RES_W-1:0] resp_neq_q,   resp_neq_d;

   // S1 payload (no reset needed, qualified by s1_valid_q)
   logic [ID_W-1:0]  s1_id_q;
   logic [A_W-1:0]   s1_a_q;
   logic [B_W-1:0]   s1_b_q;
   logic [B_W-1:0]   s1_mask_q;

   // Handshake / arbitration
   logic             stall;
   logic             advance;
   logic             accept;
   logic             xfer;
   logic             found_hi, found_lo;
   logic [PTR_W-1:0] idx_hi, idx_lo;
   logic [PTR_W-1:0] grant_idx;
   logic [A_W-1:0]   sel_a;
   logic [B_W-1:0]   sel_b;
   logic [B_W-1:0]   sel_mask;
   logic             s1_neq;

   assign stall   = resp_valid_q & ~bus.resp_ready;
   assign advance = s1_valid_q & ~stall;
   // Gating with rst_n keeps every grant low while reset is asserted.
   assign accept  = rst_n & (~s1_valid_q | advance);
   assign xfer    = accept & found_lo;

   // Round-robin pick: lowest valid index at or above rr_ptr wins; if none,
   // wrap around and take the lowest valid index overall.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      idx_hi   = '0;
      idx_lo   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (bus.req_valid[i]) begin
            found_lo = 1'b1;
            idx_lo   = PTR_W'(i);
            if (i >= int'(rr_ptr_q)) begin
               found_hi = 1'b1;
               idx_hi   = PTR_W'(i);
            end
         end
      end
   end

   assign grant_idx     = found_hi ? idx_hi : idx_lo;
   assign bus.req_ready = xfer ? (GRANT_LSB << grant_idx) : '0;

   always_comb begin
      sel_a    = bus.req_a[int'(grant_idx) * A_W +: A_W];
      sel_b    = bus.req_b[int'(grant_idx) * B_W +: B_W];
      sel_mask = bus.req_mask[int'(grant_idx) * B_W +: B_W];
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (xfer) begin
         rr_ptr_d = (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_W'(1);
      end
   end

   // ---- stage boundary: request lanes -> S1 issue register ----
   always_comb begin
      s1_valid_d = s1_valid_q;
      if (advance) s1_valid_d = 1'b0;
      if (xfer)    s1_valid_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (xfer) begin
         s1_id_q   <= ID_W'(grant_idx);
         s1_a_q    <= sel_a;
         s1_b_q    <= sel_b;
         s1_mask_q <= sel_mask;
      end
   end

   assign s1_neq = wild_neq(ext_a(s1_a_q), ext_b(s1_b_q), ext_b(s1_mask_q));

   // ---- stage boundary: S1 -> S2 response register ----
   always_comb begin
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      resp_neq_d   = resp_neq_q;
      if (advance) begin
         resp_valid_d = 1'b1;
         resp_id_d    = s1_id_q;
         resp_neq_d   = RES_W'(s1_neq);
      end else if (bus.resp_ready) begin
         resp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q     <= '0;
         s1_valid_q   <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_neq_q   <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         s1_valid_q   <= s1_valid_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_neq_q   <= resp_neq_d;
      end
   end

   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_neq   = resp_neq_q;

`ifdef WILDNEQ_ARB_STATS_EN
   logic [15:0] stat_cmp_q, stat_cmp_d;
   logic [15:0] stat_neq_q, stat_neq_d;
   logic        resp_hs;

   assign resp_hs = resp_valid_q & bus.resp_ready;

   // Counters saturate rather than wrap.
   always_comb begin
      stat_cmp_d = stat_cmp_q;
      stat_neq_d = stat_neq_q;
      if (resp_hs && (stat_cmp_q != 16'hFFFF)) stat_cmp_d = stat_cmp_q + 16'd1;
      if (resp_hs && resp_neq_q[0] && (stat_neq_q != 16'hFFFF)) begin
         stat_neq_d = stat_neq_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_cmp_q <= '0;
         stat_neq_q <= '0;
      end else begin
         stat_cmp_q <= stat_cmp_d;
         stat_neq_q <= stat_neq_d;
      end
   end

   assign stat_cmp = stat_cmp_q;
   assign stat_neq = stat_neq_q;
`endif

endmodule

// File: tb/tb_wildneq_arb.sv
module tb_wildneq_arb;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wildneq_arb_if #(.NREQ(4), .A_W(9), .B_W(6), .RES_W(1), .ID_W(2)) b0 ();
   wildneq_arb_if #(.NREQ(4), .A_W(9), .B_W(6), .RES_W(4), .ID_W(2)) b1 ();

`ifdef WILDNEQ_ARB_STATS_EN
   logic [15:0] st_cmp, st_neq, st1_cmp, st1_neq;
   int hs0 = 0;
   int nq0 = 0;
`endif

   // dut0: unsigned, 1-bit result; dut1: signed, 4-bit zero-extended result
   wildneq_arb #(.NREQ(4), .A_W(9), .B_W(6), .SIGNED(0), .RES_W(1), .ID_W(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(b0)
`ifdef WILDNEQ_ARB_STATS_EN
      , .stat_cmp(st_cmp), .stat_neq(st_neq)
`endif
   );

   wildneq_arb #(.NREQ(4), .A_W(9), .B_W(6), .SIGNED(1), .RES_W(4), .ID_W(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(b1)
`ifdef WILDNEQ_ARB_STATS_EN
      , .stat_cmp(st1_cmp), .stat_neq(st1_neq)
`endif
   );

   typedef struct packed {
      logic [1:0] id;
      logic       neq;
   } sb_t;

   typedef struct {
      int         d;
      int         r;
      logic [8:0] a;
      logic [5:0] b;
      logic [5:0] m;
      logic       e;
   } vec_t;

   sb_t  q0[$];
   sb_t  q1[$];
   logic exp0[4];
   logic exp1[4];
   int   total = 0;
   int   bad   = 0;

   task automatic check(string nm, logic [31:0] act, logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", nm, act, req);
      end
   endtask

   // Independent bit-by-bit reference of the wildcard inequality.
   function automatic logic model_neq(logic [8:0] a, logic [5:0] b, logic [5:0] m, bit sgn);
      logic bb, mm;
      for (int k = 0; k < 9; k++) begin
         if (k < 6) begin
            bb = b[k];
            mm = m[k];
         end else begin
            bb = sgn & b[5];
            mm = sgn & m[5];
         end
         if (!mm && (a[k] != bb)) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Scoreboard: push on request transfer, pop/compare on response transfer.
   // Sampled at the falling edge, where the handshake for the next rising
   // edge is already settled.
   always @(negedge clk) begin
      sb_t e;
      if (rst_n) begin
         if (b0.resp_valid && b0.resp_ready) begin
`ifdef WILDNEQ_ARB_STATS_EN
            hs0++;
            if (b0.resp_neq[0]) nq0++;
`endif
            if (q0.size() == 0) begin
               total++;
               bad++;
               $display("FAIL d0_resp_unexpected: got id %0h, want no response", b0.resp_id);
            end else begin
               e = q0.pop_front();
               check("d0_resp_id", 32'(b0.resp_id), 32'(e.id));
               check("d0_resp_neq", 32'(b0.resp_neq), 32'(e.neq));
            end
         end
         if (b1.resp_valid && b1.resp_ready) begin
            if (q1.size() == 0) begin
               total++;
               bad++;
               $display("FAIL d1_resp_unexpected: got id %0h, want no response", b1.resp_id);
            end else begin
               e = q1.pop_front();
               check("d1_resp_id", 32'(b1.resp_id), 32'(e.id));
               check("d1_resp_neq", 32'(b1.resp_neq), {31'd0, e.neq});
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (b0.req_valid[i] && b0.req_ready[i]) begin
               e.id  = 2'(i);
               e.neq = exp0[i];
               q0.push_back(e);
            end
            if (b1.req_valid[i] && b1.req_ready[i]) begin
               e.id  = 2'(i);
               e.neq = exp1[i];
               q1.push_back(e);
            end
         end
      end
   end

   task automatic set_req(int d, int i, logic [8:0] a, logic [5:0] b, logic [5:0] m, logic e);
      if (d == 0) begin
         b0.req_a[i*9 +: 9]    = a;
         b0.req_b[i*6 +: 6]    = b;
         b0.req_mask[i*6 +: 6] = m;
         exp0[i]               = e;
      end else begin
         b1.req_a[i*9 +: 9]    = a;
         b1.req_b[i*6 +: 6]    = b;
         b1.req_mask[i*6 +: 6] = m;
         exp1[i]               = e;
      end
   endtask

   // Raise valid, wait (bounded) for the grant, drop valid after the transfer edge.
   task automatic issue(int d, int i, logic [8:0] a, logic [5:0] b, logic [5:0] m, logic e);
      bit ok = 1'b0;
      set_req(d, i, a, b, m, e);
      if (d == 0) b0.req_valid[i] = 1'b1; else b1.req_valid[i] = 1'b1;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         ok = (d == 0) ? b0.req_ready[i] : b1.req_ready[i];
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL grant_timeout d%0d req%0d: got no ready, want ready", d, i);
      end
      @(posedge clk); #1;
      if (d == 0) b0.req_valid[i] = 1'b0; else b1.req_valid[i] = 1'b0;
   endtask

   task automatic drain();
      for (int c = 0; c < 60 && (q0.size() != 0 || q1.size() != 0); c++) @(posedge clk);
      #1;
      check("drain_q0_empty", 32'(q0.size()), 32'd0);
      check("drain_q1_empty", 32'(q1.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       tbl[12];
      int         seq[6];
      logic       acc[4];
      logic [8:0] ra;
      logic [5:0] rb, rm;

      tbl[0]  = '{0, 0, 9'h025, 6'h25, 6'h00, 1'b0};
      tbl[1]  = '{0, 1, 9'h1A5, 6'h25, 6'h00, 1'b1};
      tbl[2]  = '{0, 2, 9'h03F, 6'h00, 6'h3F, 1'b0};
      tbl[3]  = '{0, 3, 9'h13F, 6'h00, 6'h3F, 1'b1};
      tbl[4]  = '{0, 1, 9'h1FF, 6'h3F, 6'h00, 1'b1};
      tbl[5]  = '{0, 2, 9'h02A, 6'h2B, 6'h01, 1'b0};
      tbl[6]  = '{1, 0, 9'h1E5, 6'h25, 6'h00, 1'b0};
      tbl[7]  = '{1, 1, 9'h025, 6'h25, 6'h00, 1'b1};
      tbl[8]  = '{1, 2, 9'h005, 6'h25, 6'h20, 1'b0};
      tbl[9]  = '{1, 3, 9'h1FF, 6'h3F, 6'h00, 1'b0};
      tbl[10] = '{1, 0, 9'h0FF, 6'h3F, 6'h00, 1'b1};
      tbl[11] = '{1, 2, 9'h0AA, 6'h00, 6'h3F, 1'b0};
      seq = '{0, 1, 2, 3, 0, 1};

      b0.req_valid = '0; b0.req_a = '0; b0.req_b = '0; b0.req_mask = '0; b0.resp_ready = 1'b1;
      b1.req_valid = '0; b1.req_a = '0; b1.req_b = '0; b1.req_mask = '0; b1.resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp0[i] = 1'b0;
         exp1[i] = 1'b0;
      end

      // Reset state, with demand present
      b0.req_valid = 4'hF;
      #2;
      check("rst_req_ready", 32'(b0.req_ready), 32'd0);
      check("rst_resp_valid", 32'(b0.resp_valid), 32'd0);
      check("rst_resp_id", 32'(b0.resp_id), 32'd0);
      check("rst_resp_neq", 32'(b0.resp_neq), 32'd0);
      check("rst_d1_resp_valid", 32'(b1.resp_valid), 32'd0);
      b0.req_valid = '0;
      #21 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single request latency
      set_req(0, 0, 9'h1A5, 6'h25, 6'h00, 1'b1);
      b0.req_valid[0] = 1'b1;
      @(posedge clk); #1;
      b0.req_valid[0] = 1'b0;
      check("lat_resp_valid_t1", 32'(b0.resp_valid), 32'd0);
      @(posedge clk); #1;
      check("lat_resp_valid_t2", 32'(b0.resp_valid), 32'd1);
      check("lat_resp_id", 32'(b0.resp_id), 32'd0);
      check("lat_resp_neq", 32'(b0.resp_neq), 32'd1);
      @(posedge clk); #1;
      check("lat_resp_valid_t3", 32'(b0.resp_valid), 32'd0);

      // Table-driven compares
      for (int k = 0; k < 12; k++) issue(tbl[k].d, tbl[k].r, tbl[k].a, tbl[k].b, tbl[k].m, tbl[k].e);
      drain();

      // Backpressure: two accepted, consumer stalls 3 cycles
      b0.resp_ready = 1'b0;
      set_req(0, 1, 9'h001, 6'h00, 6'h00, 1'b1);
      set_req(0, 2, 9'h000, 6'h00, 6'h00, 1'b0);
      b0.req_valid[1] = 1'b1;
      b0.req_valid[2] = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      b0.req_valid[1] = 1'b0;
      b0.req_valid[2] = 1'b0;
      set_req(0, 3, 9'h100, 6'h00, 6'h00, 1'b1);
      b0.req_valid[3] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_resp_valid", 32'(b0.resp_valid), 32'd1);
         check("bp_req_ready", 32'(b0.req_ready), 32'd0);
         check("bp_queue_depth", 32'(q0.size()), 32'd2);
         if (q0.size() != 0) begin
            check("bp_resp_id", 32'(b0.resp_id), 32'(q0[0].id));
            check("bp_resp_neq", 32'(b0.resp_neq), 32'(q0[0].neq));
         end
      end
      @(posedge clk); #1;
      b0.resp_ready = 1'b1;
      issue(0, 3, 9'h100, 6'h00, 6'h00, 1'b1);
      drain();

      // Reset mid-stream with S2 valid and S1 full
      b0.resp_ready = 1'b0;
      b0.req_valid[1] = 1'b1;
      b0.req_valid[2] = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      b0.req_valid[1] = 1'b0;
      b0.req_valid[2] = 1'b0;
      b0.req_valid[0] = 1'b1;
      @(negedge clk); #2;
      check("mid_pre_resp_valid", 32'(b0.resp_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_resp_valid", 32'(b0.resp_valid), 32'd0);
      check("mid_rst_resp_id", 32'(b0.resp_id), 32'd0);
      check("mid_rst_resp_neq", 32'(b0.resp_neq), 32'd0);
      check("mid_rst_req_ready", 32'(b0.req_ready), 32'd0);
      q0.delete();
      q1.delete();
`ifdef WILDNEQ_ARB_STATS_EN
      hs0 = 0;
      nq0 = 0;
      check("mid_rst_stat_cmp", 32'(st_cmp), 32'd0);
      check("mid_rst_stat_neq", 32'(st_neq), 32'd0);
`endif
      b0.req_valid  = '0;
      b0.resp_ready = 1'b1;
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Round robin with all requesters held valid; first grant after reset is 0
      for (int i = 0; i < 4; i++) set_req(0, i, 9'(i), 6'h00, 6'h00, (i != 0));
      b0.req_valid = 4'hF;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("rr_grant", 32'(b0.req_ready), 32'(4'b0001 << seq[k]));
      end
      @(posedge clk); #1;
      b0.req_valid = '0;
      drain();

      // Random traffic with random consumer backpressure
      for (int cyc = 0; cyc < 80; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) acc[i] = b0.req_valid[i] & b0.req_ready[i];
         @(posedge clk); #1;
         for (int i = 0; i < 4; i++) begin
            if (!b0.req_valid[i] || acc[i]) begin
               if ($urandom_range(0, 1) != 0) begin
                  ra = 9'($urandom);
                  rb = 6'($urandom);
                  rm = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00;
                  if ($urandom_range(0, 2) == 0) rb = ra[5:0];
                  set_req(0, i, ra, rb, rm, model_neq(ra, rb, rm, 1'b0));
                  b0.req_valid[i] = 1'b1;
               end else begin
                  b0.req_valid[i] = 1'b0;
               end
            end
         end
         b0.resp_ready = ($urandom_range(0, 3) != 0);
      end
      b0.req_valid  = '0;
      b0.resp_ready = 1'b1;
      drain();

`ifdef WILDNEQ_ARB_STATS_EN
      check("stat_cmp", 32'(st_cmp), 32'(hs0));
      check("stat_neq", 32'(st_neq), 32'(nq0));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wildneq_arb.md
Name: wildneq_arb

Overview:
- Shared, pipelined wildcard-inequality (!=?) compare unit serving NREQ requesters through round-robin arbitration.
- Each request carries operand A, operand B and a wildcard mask marking B's don't-care bits; the mask is the 2-state stand-in for X/Z in B.
- Returns a tagged, zero-extended result on a single valid/ready response port.
- Sits between pattern-match clients and one comparator instance, replacing per-client comparators.

Parameters:
- NREQ, 4, number of requesters (2..16)
- A_W, 9, operand A width
- B_W, 6, operand B and mask width
- SIGNED, 0, 1 = operands sign-extended to compare width, 0 = zero-extended
- RES_W, 1, result width; 1-bit compare result zero-extended to RES_W
- ID_W, 2, requester id width, >= clog2(NREQ)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant/accept
- req_a  in  NREQ*A_W  operand A, requester i at [i*A_W +: A_W]
- req_b  in  NREQ*B_W  operand B, packed as req_a
- req_mask  in  NREQ*B_W  wildcard mask, 1 = don't-care bit of B
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumer ready
- resp_id  out  ID_W  index of originating requester
- resp_neq  out  RES_W  compare result, bit 0 significant, upper bits 0

Behaviour:
- Reset (async assert, sync release): req_ready=0, resp_valid=0, resp_id=0, resp_neq=0, s1_valid=0, rr_ptr=0.
- Compare width CW = max(A_W,B_W).
- SIGNED=0: A, B and mask zero-extended to CW.
- SIGNED=1: A and B sign-extended; mask extended by replicating mask MSB, so a wildcarded sign bit stays wildcarded.
- Extended B bits are compared normally unless masked.
- neq = |((A ^ B) & ~mask) over CW bits; all-masked gives neq=0.
- Pipeline: S1 issue register (s1_valid, id, A, B, mask); S2 output register (resp_*).
- stall = resp_valid & ~resp_ready.
- S1 advances into S2 when s1_valid & ~stall.
- S1 accepts a new request when ~s1_valid | advance.
- Arbitration is combinational: when S1 can accept, exactly one req_ready bit is high, for the first valid requester scanning from rr_ptr upward modulo NREQ. Otherwise req_ready=0.
- req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready and must hold payload stable while valid is high and ready is low.
- On a transfer to requester g, rr_ptr <= (g+1) mod NREQ; wraps from NREQ-1 to 0. rr_ptr unchanged when there is no transfer.
- Latency: request accepted at edge T gives resp_valid high after edge T+1 when not stalled. Throughput is one response per cycle.
- Stall: resp_* hold stable; S1 holds. With S1 full, req_ready=0 for all requesters.
- S2 unload and S1 advance in the same cycle (resp_ready=1) is lossless; simultaneous S1 load and advance is allowed.
- No response is dropped, duplicated or reordered.
- Reset mid-operation discards in-flight requests; outputs drop immediately on rst_n low.

Optional Feature:
- Macro WILDNEQ_ARB_STATS_EN.
- Defined: adds outputs stat_cmp[15:0] and stat_neq[15:0].
  - stat_cmp increments on each response handshake (resp_valid & resp_ready).
  - stat_neq increments on each response handshake with neq=1.
  - Both saturate at 16'hFFFF, reset to 0, and hold while stalled.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single request (default params, req 0):
  - a=9'h1A5, b=6'h25, mask=0 -> resp_neq=1, resp_id=0, resp_valid two cycles after the request cycle.
  - a=9'h025, b=6'h25, mask=0 -> resp_neq=0.
- Wildcard, SIGNED=0, b=6'h00, mask=6'h3F:
  - a=9'h03F -> neq=0.
  - a=9'h13F -> neq=1 (extended bit 8 unmasked).
- Sign extension, SIGNED=1, b=6'h25 (extends to 9'h1E5), mask=0:
  - a=9'h1E5 -> neq=0.
  - a=9'h025 -> neq=1.
  - With mask=6'h20, a=9'h005 -> neq=0 (sign bit and extension wildcarded).
- Round robin: all four req_valid held high, resp_ready=1 -> grants and resp_id sequence 0,1,2,3,0,1, one per cycle, rr_ptr wraps 3->0.
- Backpressure: accept two requests, resp_ready=0 for 3 cycles -> resp_* stable, all req_ready=0. Then resp_ready=1 -> both responses drain in order, no loss.
- Reset mid-stream: rst_n low while resp_valid=1 and S1 full -> outputs 0 immediately. After release, next grant goes to requester 0; with the stats macro defined, both counters read 0.
